// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// Module      : ram_fifo_pkg
// Description : Shared constants and helpers for the ram_fifo block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

  localparam int C_DEFAULT_ADDR_WIDTH = 9;
  localparam int C_DEFAULT_DATA_WIDTH = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_sdp.sv
// ============================================================================
// Module      : ram_sdp
// Description : Single-clock simple dual-port RAM, registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sdp
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = C_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] dout_q;

  // No reset on the array or read register so the tools map this onto BRAM.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[waddr] <= din;
    end
    if (read_en) begin
      dout_q <= mem[raddr];
    end
  end

  assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/ram_fifo.sv
// ============================================================================
// Module      : ram_fifo
// Description : Single-clock BRAM FIFO with count, flags and read-valid strobe.
//               Define RAM_FIFO_ERROR_FLAGS_EN for sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = C_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = C_DEFAULT_DATA_WIDTH,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
`ifdef RAM_FIFO_ERROR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] C_AFULL = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

  logic                  wr_ok;
  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  dout_valid_q, dout_valid_d;

  // Flags are computed from the next count so they line up with count_q.
  always_comb begin
    wr_ok         = write_en && !full_q;
    rd_ok         = read_en && !empty_q;
    wptr_d        = wptr_q + ADDR_WIDTH'(wr_ok);
    rptr_d        = rptr_q + ADDR_WIDTH'(rd_ok);
    count_d       = count_q + (ADDR_WIDTH + 1)'(wr_ok) - (ADDR_WIDTH + 1)'(rd_ok);
    empty_d       = (count_d == '0);
    full_d        = (count_d == C_DEPTH);
    almost_full_d = (count_d >= C_AFULL);
    dout_valid_d  = rd_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      dout_valid_q  <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

`ifdef RAM_FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q || (write_en && full_q);
    underflow_d = underflow_q || (read_en && empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  ram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .write_en (wr_ok),
    .waddr    (wptr_q),
    .din      (din),
    .read_en  (rd_ok),
    .raddr    (rptr_q),
    .dout     (dout)
  );

  assign dout_valid  = dout_valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;

endmodule

`default_nettype wire
